// File: rtl/phase_scheduler.sv
// phase_scheduler: four-lane green-slot scheduler with density-scaled slots, starvation priority, emergency preemption and all-red clearance
module phase_scheduler #(
  parameter int SLOT_BASE    = 100,
  parameter int SLOT_STEP    = 50,
  parameter int ALL_RED_TIME = 20,
  parameter int MAX_WAIT     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dens,
  input  logic [3:0] ped,
  input  logic [3:0] emergency,
  input  logic [3:0] lane_red,
  output logic [3:0] grant,
  output logic [1:0] cur_lane,
  output logic [2:0] state,
  output logic       emg_active
);
  typedef enum logic [2:0] {IDLE, GRANT, WAIT_RED, ALL_RED, EMG} state_t;
  state_t      st;
  logic [1:0]  ptr;
  logic [2:0]  wcnt [4];
  logic [15:0] slot, el, clr;
  logic [3:0]  dem;
  logic [1:0]  sel, emg_lane;
  logic [31:0] t_sum;
  logic [15:0] t_sel;
  logic        gap;
  assign state = st;
  // demand per lane, round-robin pick with starved lanes first, lowest emergency lane, slot length
  always_comb begin
    sel = ptr;
    emg_lane = 2'd0;
    for (int i = 0; i < 4; i++) dem[i] = (dens[2*i +: 2] != 2'd0) || ped[i];
    for (int i = 3; i >= 0; i--) if (dem[ptr + 2'(i)]) sel = ptr + 2'(i);
    for (int i = 3; i >= 0; i--) if (dem[ptr + 2'(i)] && wcnt[ptr + 2'(i)] == 3'(MAX_WAIT)) sel = ptr + 2'(i);
    for (int i = 3; i >= 0; i--) if (emergency[i]) emg_lane = 2'(i);
    t_sum = 32'(SLOT_BASE) + 32'(SLOT_STEP) * {30'd0, dens[{sel, 1'b0} +: 2]};
    t_sel = t_sum > 32'd65535 ? 16'hFFFF : t_sum[15:0];
    gap = (32'(el) + 32'd1 >= 32'(SLOT_BASE)) && !dem[cur_lane];
  end
  // scheduler FSM with registered grant, lane, pointer and starvation counters
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      grant <= 4'd0;
      cur_lane <= 2'd0;
      emg_active <= 1'b0;
      ptr <= 2'd0;
      for (int i = 0; i < 4; i++) wcnt[i] <= 3'd0;
      slot <= 16'd0;
      el <= 16'd0;
      clr <= 16'd0;
    end else begin
      case (st)
        IDLE: begin
          if (|emergency) begin
            st <= EMG;
            cur_lane <= emg_lane;
            grant <= 4'd1 << emg_lane;
            emg_active <= 1'b1;
          end else if (|dem) begin
            st <= GRANT;
            cur_lane <= sel;
            grant <= 4'd1 << sel;
            slot <= t_sel;
            el <= 16'd0;
            for (int i = 0; i < 4; i++)
              wcnt[i] <= (2'(i) == sel) ? 3'd0 :
                         (dem[i] && wcnt[i] != 3'(MAX_WAIT)) ? wcnt[i] + 3'd1 : wcnt[i];
          end
        end
        GRANT: begin
          el <= el + 16'd1;
          slot <= slot - 16'd1;
          if (emergency[cur_lane]) begin
            st <= EMG;
            emg_active <= 1'b1;
            ptr <= cur_lane + 2'd1;
          end else if (|emergency || slot == 16'd1 || gap) begin
            st <= WAIT_RED;
            grant <= 4'd0;
            ptr <= cur_lane + 2'd1;
          end
        end
        WAIT_RED: begin
          if (lane_red[cur_lane]) begin
            st <= ALL_RED;
            clr <= 16'(ALL_RED_TIME);
          end
        end
        ALL_RED: begin
          clr <= clr - 16'd1;
          if (clr == 16'd1) st <= IDLE;
        end
        EMG: begin
          if (!emergency[cur_lane]) begin
            st <= WAIT_RED;
            grant <= 4'd0;
            emg_active <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
